// File: rtl/clint.sv
// clint: core-local interruptor with msip, mtime/mtimecmp and prescaled timebase
module clint #(
  parameter int MTIME_DIV = 1,
  parameter int ADDR_WIDTH = 16,
  parameter int SIZE_WIDTH = 3,
  parameter int REG_DATA_WIDTH = 32,
  parameter int BUS_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     bus_clint_read_addr,
  input  logic [SIZE_WIDTH-1:0]     bus_clint_read_size,
  input  logic                      bus_clint_rd,
  input  logic [ADDR_WIDTH-1:0]     bus_clint_write_addr,
  input  logic [SIZE_WIDTH-1:0]     bus_clint_write_size,
  input  logic [REG_DATA_WIDTH-1:0] bus_clint_data,
  input  logic                      bus_clint_wr,
  output logic [BUS_DATA_WIDTH-1:0] clint_bus_data,
  output logic                      clint_int_software_req,
  output logic                      clint_int_timer_req
);
  localparam logic [ADDR_WIDTH-1:0] A_MSIP  = ADDR_WIDTH'(16'h0000);
  localparam logic [ADDR_WIDTH-1:0] A_CMPLO = ADDR_WIDTH'(16'h4000);
  localparam logic [ADDR_WIDTH-1:0] A_CMPHI = ADDR_WIDTH'(16'h4004);
  localparam logic [ADDR_WIDTH-1:0] A_MTLO  = ADDR_WIDTH'(16'hBFF8);
  localparam logic [ADDR_WIDTH-1:0] A_MTHI  = ADDR_WIDTH'(16'hBFFC);
  function automatic logic lanes_ok(input logic [1:0] off, input logic [SIZE_WIDTH-1:0] sz);
    return (sz == SIZE_WIDTH'(1) || sz == SIZE_WIDTH'(2) || sz == SIZE_WIDTH'(4)) &&
           ({2'b00, off} + 4'(sz) <= 4'd4);
  endfunction
  function automatic logic [31:0] size_mask(input logic [SIZE_WIDTH-1:0] sz);
    return sz == SIZE_WIDTH'(1) ? 32'h0000_00FF : sz == SIZE_WIDTH'(2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] mask, input logic [31:0] data);
    return (old & ~mask) | (data & mask);
  endfunction
  logic [15:0] pre_q, pre_d;
  logic [63:0] mtime_q, mtime_d, cmp_q, cmp_d;
  logic msip_q, msip_d, timer_q, timer_d;
  logic [31:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] ra_w, wa_w;
  logic [31:0] rword, wmask, wdata;
  logic [1:0] roff, woff;
  logic tick, wvalid, mt_wr;
  always_comb begin
    ra_w = {bus_clint_read_addr[ADDR_WIDTH-1:2], 2'b00};
    wa_w = {bus_clint_write_addr[ADDR_WIDTH-1:2], 2'b00};
    roff = bus_clint_read_addr[1:0];
    woff = bus_clint_write_addr[1:0];
    tick = pre_q == 16'(MTIME_DIV - 1);
    pre_d = tick ? '0 : pre_q + 16'd1;
    rword = ra_w == A_MSIP  ? {31'b0, msip_q} :
            ra_w == A_CMPLO ? cmp_q[31:0] :
            ra_w == A_CMPHI ? cmp_q[63:32] :
            ra_w == A_MTLO  ? mtime_q[31:0] :
            ra_w == A_MTHI  ? mtime_q[63:32] : '0;
    rdata_d = !bus_clint_rd ? rdata_q :
              lanes_ok(roff, bus_clint_read_size) ? (rword >> {roff, 3'b000}) & size_mask(bus_clint_read_size) : '0;
    wvalid = bus_clint_wr && lanes_ok(woff, bus_clint_write_size);
    wmask = wvalid ? size_mask(bus_clint_write_size) << {woff, 3'b000} : '0;
    wdata = bus_clint_data[31:0] << {woff, 3'b000};
    msip_d = (wa_w == A_MSIP && wmask[0]) ? wdata[0] : msip_q;
    cmp_d = {wa_w == A_CMPHI ? merge(cmp_q[63:32], wmask, wdata) : cmp_q[63:32],
             wa_w == A_CMPLO ? merge(cmp_q[31:0], wmask, wdata) : cmp_q[31:0]};
    mt_wr = wvalid && (wa_w == A_MTLO || wa_w == A_MTHI);
    mtime_d = mt_wr ? {wa_w == A_MTHI ? merge(mtime_q[63:32], wmask, wdata) : mtime_q[63:32],
                       wa_w == A_MTLO ? merge(mtime_q[31:0], wmask, wdata) : mtime_q[31:0]}
                    : mtime_q + 64'(tick);
    timer_d = mtime_q >= cmp_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      mtime_q <= '0;
      cmp_q   <= '1;
      msip_q  <= 1'b0;
      timer_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      pre_q   <= pre_d;
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      msip_q  <= msip_d;
      timer_q <= timer_d;
      rdata_q <= rdata_d;
    end
  end
  assign clint_bus_data = BUS_DATA_WIDTH'(rdata_q);
  assign clint_int_software_req = msip_q;
  assign clint_int_timer_req = timer_q;
endmodule

// File: doc/clint.md
CLINT -- requirements
Module: clint

Interface
REQ-001 Parameter MTIME_DIV, default 1, meaning clk cycles per mtime increment (legal range 1..65535).
REQ-002 Port clk  input  1  core clock; the single clock domain, all state updates on its rising edge.
REQ-003 Port rst  input  1  reset; synchronous and active-high.
REQ-004 Port bus_clint_read_addr  input  ADDR_WIDTH  read address, offset relative to CLINT base.
REQ-005 Port bus_clint_read_size  input  SIZE_WIDTH  read size in bytes: 1, 2 or 4.
REQ-006 Port bus_clint_rd  input  1  read request, one-cycle strobe.
REQ-007 Port bus_clint_write_addr  input  ADDR_WIDTH  write address, offset relative to CLINT base.
REQ-008 Port bus_clint_write_size  input  SIZE_WIDTH  write size in bytes: 1, 2 or 4.
REQ-009 Port bus_clint_data  input  REG_DATA_WIDTH  write data, right-aligned (bits [8*size-1:0] valid).
REQ-010 Port bus_clint_wr  input  1  write request, one-cycle strobe.
REQ-011 Port clint_bus_data  output  BUS_DATA_WIDTH  registered read data, right-aligned and zero-extended.
REQ-012 Port clint_int_software_req  output  1  machine software interrupt (msip bit 0).
REQ-013 Port clint_int_timer_req  output  1  machine timer interrupt (mtime >= mtimecmp).

Function
REQ-014 The register map SHALL be: msip 0x0000 (bit 0 writable, bits 31:1 read 0); mtimecmp_lo 0x4000; mtimecmp_hi 0x4004; mtime_lo 0xBFF8; mtime_hi 0xBFFC.
REQ-015 mtime and mtimecmp SHALL each be 64-bit unsigned registers.
REQ-016 Word selection SHALL use addr[ADDR_WIDTH-1:2].
REQ-017 Byte lanes SHALL be addr[1:0] .. addr[1:0]+size-1.
REQ-018 An access whose lanes cross a word boundary, whose size is not 1/2/4, or whose word is unmapped SHALL be ignored on write and return 0 on read.
REQ-019 A write SHALL update only the addressed byte lanes, taking lane k from bus_clint_data[8k+7:8k]; the register takes its new value at the clock edge that samples bus_clint_wr.
REQ-020 A read SHALL have one-cycle latency: clint_bus_data in cycle N+1 = (word >> 8*addr[1:0]) masked to 8*size bits, for the rd sampled in cycle N.
REQ-021 clint_bus_data SHALL hold its last value in cycles that follow no read.
REQ-022 A prescaler counter SHALL count 0..MTIME_DIV-1 and wrap; mtime SHALL increment by 1 (64-bit, wrapping from all-ones to 0) in each cycle where the counter equals MTIME_DIV-1.
REQ-023 With MTIME_DIV=1, mtime SHALL increment every cycle.
REQ-024 A write to mtime_lo or mtime_hi SHALL suppress that cycle's increment.
REQ-025 After an mtime write, both halves SHALL hold exactly the old value with the written lanes replaced; the prescaler is not reset.
REQ-026 A read and a write in the same cycle SHALL both be performed; a read of the written word returns the pre-write value.
REQ-027 clint_int_timer_req SHALL be registered: it equals (mtime >= mtimecmp), unsigned 64-bit, evaluated on the register values present in the previous cycle.
REQ-028 clint_int_timer_req SHALL deassert one cycle after mtimecmp is written above mtime.
REQ-029 clint_int_software_req SHALL equal the msip bit 0 register directly, with no extra delay.
REQ-030 The block SHALL never stall or back-pressure: no ack outputs, every request completes in the defined latency.

Reset
REQ-031 While rst is high at a clock edge, the block SHALL set: mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0, clint_bus_data=0, clint_int_timer_req=0; reads and writes in that cycle are ignored.
REQ-032 The first mtime increment SHALL occur MTIME_DIV cycles after the first edge with rst low.
REQ-033 Reset asserted mid-operation SHALL override any concurrent write or pending read; no read data from before reset SHALL appear after it.

Verification
REQ-034 Reset release, MTIME_DIV=1, 10 idle cycles, read 4B @0xBFF8 -> returned value 10 ±1 (defined exactly by read cycle index); timer_req=0 throughout.
REQ-035 Write 4B 0x0000_0005 @0x4000, then 0 @0x4004, from mtime=0 -> timer_req rises exactly one cycle after mtime reaches 5; then write 0xFFFF_FFFF @0x4004 -> timer_req falls the next cycle.
REQ-036 Write 1B 0x01 @0x0000 -> software_req=1 the cycle after the write; write 4B 0xFFFF_FFFE @0x0000 -> software_req=0; read @0x0000 -> 0.
REQ-037 Write 4B 0xFFFF_FFFF to both mtime halves, MTIME_DIV=1 -> two cycles later mtime_hi reads 0 and mtime_lo reads 0 (wrap); same-cycle increment suppressed on each write.
REQ-038 Sub-word access: write 2B 0xABCD @0x4002, read 1B @0x4003 -> 0xAB; read 2B @0x4003 (crossing) -> 0; write 4B @0x1234 -> no register changes.
REQ-039 MTIME_DIV=4: mtime increments exactly every 4 cycles; assert rst during a pending read -> clint_bus_data=0 and all registers at reset values the following cycle.
